// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared widths, defaults and FSM encoding
// for the period_meter block and its synchronizer.
package period_meter_pkg;

  localparam int CNT_W_DEF = 28;

  localparam logic [27:0] TIMEOUT_DEF =
    28'd250_000_000;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t MEASURE = 2'd1;
  localparam state_t TO      = 2'd2;

endpackage

// File: rtl/period_meter_sync_edge_det.sv
// sync_edge_det: 2-FF synchronizer plus delay flop,
// giving a clean level (s1) and a one-cycle rise pulse.
module sync_edge_det (
  input  logic clk_ht,
  input  logic rst_n,
  input  logic sig_in,
  output logic s1,
  output logic rise
);

  logic s0;
  logic s_d;

  always_ff @(posedge clk_ht or negedge rst_n) begin
    if (!rst_n) begin
      s0  <= 1'b0;
      s1  <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s0  <= sig_in;
      s1  <= s0;
      s_d <= s1;
    end
  end

  assign rise = s1 & ~s_d;

endmodule

// File: rtl/period_meter.sv
// period_meter: counts clk_ht cycles between rising edges of sig_in.
// Define PERIOD_METER_DUTY_EN to also report the high time.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT =
    CNT_W'(TIMEOUT_DEF)
) (
  input  logic             clk_ht,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             s1;
  logic             rise;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             at_limit;

  sync_edge_det u_sync (
    .clk_ht (clk_ht),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .s1     (s1),
    .rise   (rise)
  );

  assign at_limit = (cnt == TIMEOUT - ONE);

  // A rise in the limit cycle is a normal measurement, not a timeout.
  always_ff @(posedge clk_ht or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period <= cnt;
            valid  <= 1'b1;
            cnt    <= ONE;
          end else if (at_limit) begin
            state   <= TO;
            timeout <= 1'b1;
            period  <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        TO: begin
          if (rise) begin
            state   <= MEASURE;
            timeout <= 1'b0;
            cnt     <= ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hi_cnt;

  // hi_cnt restarts at 1: s1 is already high in the rise cycle.
  always_ff @(posedge clk_ht or negedge rst_n) begin
    if (!rst_n) begin
      hi_cnt    <= '0;
      high_time <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rise) hi_cnt <= ONE;
        end
        MEASURE: begin
          if (rise) begin
            high_time <= hi_cnt;
            hi_cnt    <= ONE;
          end else if (at_limit) begin
            high_time <= '0;
            hi_cnt    <= '0;
          end else if (s1) begin
            hi_cnt <= hi_cnt + ONE;
          end
        end
        TO: begin
          if (rise) hi_cnt <= ONE;
        end
        default: begin
          hi_cnt <= '0;
        end
      endcase
    end
  end
`else
  logic unused_s1;

  assign unused_s1 = s1;
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: random and directed waveforms checked against
// an edge-list reference model of the period measurement.
`timescale 1ns/1ps
module tb_period_meter;

  localparam int W    = 28;
  localparam int T    = 100;
  localparam int MAXN = 1024;
  localparam int LAT  = 2;

  logic         clk_ht = 1'b0;
  logic         rst_n  = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  period_meter #(
    .CNT_W   (W),
    .TIMEOUT (28'd100)
  ) dut (
    .clk_ht    (clk_ht),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  always #5 clk_ht = ~clk_ht;

  int checks = 0;
  int errors = 0;

  bit           wave   [MAXN];
  int           n;
  bit           e_val  [MAXN+4];
  int           e_per  [MAXN+4];
  int           e_hi   [MAXN+4];
  bit           e_to   [MAXN+4];
  bit           ev_v   [MAXN+4];
  int           ev_p   [MAXN+4];
  int           ev_h   [MAXN+4];
  bit           ev_s   [MAXN+4];
  bit           ev_c   [MAXN+4];
  logic         o_val  [MAXN+4];
  logic [W-1:0] o_per  [MAXN+4];
  logic [W-1:0] o_hi   [MAXN+4];
  logic         o_to   [MAXN+4];

  task automatic clear_wave();
    n = 0;
  endtask

  task automatic add_level(input bit v, input int len);
    for (int i = 0; i < len; i++) begin
      if (n < MAXN) begin
        wave[n] = v;
        n++;
      end
    end
  endtask

  task automatic add_seg(input int hi, input int lo);
    add_level(1'b1, hi);
    add_level(1'b0, lo);
  endtask

  // Model: a period is the distance between consecutive rising
  // edges of the driven stream; a gap of T or more is a timeout.
  task automatic build_expect();
    int r[$];
    int cur_p;
    int cur_h;
    bit cur_t;
    for (int k = 0; k < n + LAT; k++) begin
      ev_v[k] = 0; ev_p[k] = 0; ev_h[k] = 0;
      ev_s[k] = 0; ev_c[k] = 0;
    end
    for (int i = 0; i < n; i++)
      if (wave[i] && (i == 0 || !wave[i-1]))
        r.push_back(i);
    for (int j = 0; j < r.size(); j++) begin
      int p;
      p = r[j];
      if (j + 1 < r.size() && r[j+1] - p <= T - 1) begin
        int q;
        int hi;
        q  = r[j+1];
        hi = 0;
        for (int x = p; x < q; x++) hi += int'(wave[x]);
        ev_v[q+LAT] = 1;
        ev_p[q+LAT] = q - p;
        ev_h[q+LAT] = hi;
      end else begin
        if (p + T + 1 < n + LAT) ev_s[p+T+1] = 1;
        if (j + 1 < r.size()) ev_c[r[j+1]+LAT] = 1;
      end
    end
    cur_p = 0; cur_h = 0; cur_t = 0;
    for (int k = 0; k < n + LAT; k++) begin
      if (ev_s[k]) begin
        cur_t = 1; cur_p = 0; cur_h = 0;
      end
      if (ev_c[k]) cur_t = 0;
      if (ev_v[k]) begin
        cur_p = ev_p[k]; cur_h = ev_h[k];
      end
      e_val[k] = ev_v[k];
      e_per[k] = cur_p;
`ifdef PERIOD_METER_DUTY_EN
      e_hi[k] = cur_h;
`else
      e_hi[k] = 0;
`endif
      e_to[k] = cur_t;
    end
  endtask

  // Drives one sample per cycle and records outputs at negedge.
  task automatic drive_wave();
    build_expect();
    for (int k = 0; k < n + LAT; k++) begin
      sig_in = (k < n) ? wave[k] : wave[n-1];
      @(posedge clk_ht);
      @(negedge clk_ht);
      o_val[k] = valid;
      o_per[k] = period;
      o_hi[k]  = high_time;
      o_to[k]  = timeout;
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk_ht);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sig_in = 1'($urandom);
      @(negedge clk_ht);
      checks++;
      if (valid !== 1'b0 || period !== '0 ||
          high_time !== '0 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d: got v=%b p=%0d h=%0d to=%b, want all 0",
                 i, valid, period, high_time, timeout);
      end
    end
    sig_in = 1'b0;
    rst_n  = 1'b1;
    clear_wave();
    add_level(1'b0, 2);
    for (int i = 0; i < 3; i++) add_seg(4, 4);
    drive_wave();
    for (int k = 0; k < n + LAT; k++) begin
      checks++;
      if (o_val[k] !== e_val[k] || o_per[k] !== W'(e_per[k]) ||
          o_hi[k] !== W'(e_hi[k]) || o_to[k] !== e_to[k]) begin
        errors++;
        $display("FAIL reset_first k=%0d: got v=%b p=%0d h=%0d to=%b, want v=%b p=%0d h=%0d to=%b",
                 k, o_val[k], o_per[k], o_hi[k], o_to[k],
                 e_val[k], e_per[k], e_hi[k], e_to[k]);
      end
    end
  endtask

  task automatic test_square();
    do_reset();
    clear_wave();
    add_level(1'b0, $urandom_range(1, 5));
    for (int i = 0; i < 8; i++) add_seg(5, 5);
    drive_wave();
    for (int k = 0; k < n + LAT; k++) begin
      checks++;
      if (o_val[k] !== e_val[k] || o_per[k] !== W'(e_per[k]) ||
          o_hi[k] !== W'(e_hi[k]) || o_to[k] !== e_to[k]) begin
        errors++;
        $display("FAIL square k=%0d: got v=%b p=%0d h=%0d to=%b, want v=%b p=%0d h=%0d to=%b",
                 k, o_val[k], o_per[k], o_hi[k], o_to[k],
                 e_val[k], e_per[k], e_hi[k], e_to[k]);
      end
    end
  endtask

  task automatic test_period_change();
    do_reset();
    clear_wave();
    add_level(1'b0, 3);
    for (int i = 0; i < 4; i++) add_seg(5, 5);
    for (int i = 0; i < 5; i++) add_seg(3, 4);
    drive_wave();
    for (int k = 0; k < n + LAT; k++) begin
      checks++;
      if (o_val[k] !== e_val[k] || o_per[k] !== W'(e_per[k]) ||
          o_hi[k] !== W'(e_hi[k]) || o_to[k] !== e_to[k]) begin
        errors++;
        $display("FAIL change k=%0d: got v=%b p=%0d h=%0d to=%b, want v=%b p=%0d h=%0d to=%b",
                 k, o_val[k], o_per[k], o_hi[k], o_to[k],
                 e_val[k], e_per[k], e_hi[k], e_to[k]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    clear_wave();
    add_level(1'b0, 2);
    add_seg(5, 94);
    add_seg(5, 95);
    add_seg(5, 5);
    add_seg(3, 130);
    add_seg(4, 4);
    add_seg(4, 4);
    add_level(1'b1, 1);
    drive_wave();
    for (int k = 0; k < n + LAT; k++) begin
      checks++;
      if (o_val[k] !== e_val[k] || o_per[k] !== W'(e_per[k]) ||
          o_hi[k] !== W'(e_hi[k]) || o_to[k] !== e_to[k]) begin
        errors++;
        $display("FAIL timeout k=%0d: got v=%b p=%0d h=%0d to=%b, want v=%b p=%0d h=%0d to=%b",
                 k, o_val[k], o_per[k], o_hi[k], o_to[k],
                 e_val[k], e_per[k], e_hi[k], e_to[k]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    clear_wave();
    add_level(1'b0, $urandom_range(1, 6));
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0)
        add_seg($urandom_range(1, 12), $urandom_range(85, 110));
      else
        add_seg($urandom_range(1, 12), $urandom_range(1, 12));
    end
    add_level(1'b1, 1);
    drive_wave();
    for (int k = 0; k < n + LAT; k++) begin
      checks++;
      if (o_val[k] !== e_val[k] || o_per[k] !== W'(e_per[k]) ||
          o_hi[k] !== W'(e_hi[k]) || o_to[k] !== e_to[k]) begin
        errors++;
        $display("FAIL random k=%0d: got v=%b p=%0d h=%0d to=%b, want v=%b p=%0d h=%0d to=%b",
                 k, o_val[k], o_per[k], o_hi[k], o_to[k],
                 e_val[k], e_per[k], e_hi[k], e_to[k]);
      end
    end
  endtask

  task automatic test_period2_async_reset();
    do_reset();
    clear_wave();
    add_level(1'b0, 1);
    for (int i = 0; i < 20; i++) add_seg(1, 1);
    drive_wave();
    for (int k = 0; k < n + LAT; k++) begin
      checks++;
      if (o_val[k] !== e_val[k] || o_per[k] !== W'(e_per[k]) ||
          o_hi[k] !== W'(e_hi[k]) || o_to[k] !== e_to[k]) begin
        errors++;
        $display("FAIL period2 k=%0d: got v=%b p=%0d h=%0d to=%b, want v=%b p=%0d h=%0d to=%b",
                 k, o_val[k], o_per[k], o_hi[k], o_to[k],
                 e_val[k], e_per[k], e_hi[k], e_to[k]);
      end
    end
    @(posedge clk_ht);
    #2 rst_n = 1'b0;
    sig_in = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || period !== '0 ||
        high_time !== '0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b p=%0d h=%0d to=%b, want all 0",
               valid, period, high_time, timeout);
    end
    @(posedge clk_ht);
    @(negedge clk_ht);
    rst_n = 1'b1;
    clear_wave();
    add_level(1'b0, 3);
    for (int i = 0; i < 5; i++) add_seg(2, 3);
    drive_wave();
    for (int k = 0; k < n + LAT; k++) begin
      checks++;
      if (o_val[k] !== e_val[k] || o_per[k] !== W'(e_per[k]) ||
          o_hi[k] !== W'(e_hi[k]) || o_to[k] !== e_to[k]) begin
        errors++;
        $display("FAIL after_reset k=%0d: got v=%b p=%0d h=%0d to=%b, want v=%b p=%0d h=%0d to=%b",
                 k, o_val[k], o_per[k], o_hi[k], o_to[k],
                 e_val[k], e_per[k], e_hi[k], e_to[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_period_change();
    test_timeout();
    test_random();
    test_period2_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
